// File: rtl/fir_pkg.sv
// Shared parameters, FSM encoding and tap-slice helper for the FIR tap-bank MAC.
package fir_pkg;

  localparam int unsigned TAPS     = 10;
  localparam int unsigned SAMPLE_W = 3;
  localparam int unsigned COEF_W   = 16;
  localparam int unsigned CNT_W    = $clog2(TAPS);
  localparam int unsigned PROD_W   = SAMPLE_W + COEF_W;
  localparam int unsigned ACC_W    = SAMPLE_W + COEF_W + $clog2(TAPS);
  localparam int unsigned BUS_W    = TAPS * SAMPLE_W;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Tap k occupies bus[SAMPLE_W*k +: SAMPLE_W]; k = 0 is the newest sample.
  function automatic logic [SAMPLE_W-1:0] tap_slice(input logic [BUS_W-1:0] bus,
                                                    input logic [CNT_W-1:0] k);
    return bus[k*SAMPLE_W +: SAMPLE_W];
  endfunction

endpackage

// File: rtl/fir_coef_regfile.sv
// Coefficient register bank: range-checked writes allowed only while idle, async read by tap index.
module fir_coef_regfile
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              allow,
  input  logic [CNT_W-1:0]  addr,
  input  logic [COEF_W-1:0] wdata,
  input  logic [CNT_W-1:0]  raddr,
  output logic [COEF_W-1:0] rdata,
  output logic              err
);

  logic [COEF_W-1:0] coef_q [TAPS];
  logic              err_q;
  logic              in_range;
  logic              accept;

  assign in_range = (addr <= CNT_W'(TAPS - 1));
  assign accept   = wr & allow & in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        coef_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      err_q <= wr & ~accept;
      if (accept) begin
        coef_q[addr] <= wdata;
      end
    end
  end

  assign rdata = coef_q[raddr];
  assign err   = err_q;

endmodule

// File: rtl/fir_tap_mac.sv
// Sequential one-tap-per-clock MAC over a captured tap bank; emits one registered partial sum.
module fir_tap_mac
  import fir_pkg::*;
(
  input  logic              iClk12M,
  input  logic              iRst,
  input  logic              iEnMac,
  input  logic [BUS_W-1:0]  iDelay,
  input  logic              iCoefWr,
  input  logic [CNT_W-1:0]  iCoefAddr,
  input  logic [COEF_W-1:0] iCoefData,
  output logic [ACC_W-1:0]  oMac,
  output logic              oMacValid,
  output logic              oBusy,
  output logic              oOverrun,
  output logic              oCoefErr
);

  state_e             state_q, state_d;
  logic [BUS_W-1:0]   shadow_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   k_q;
  logic [ACC_W-1:0]   mac_q;
  logic               valid_q;
  logic               overrun_q;

  logic               load;
  logic               step;
  logic               done;
  logic               busy;
  logic               last_k;
  logic [COEF_W-1:0]  coef_rd;
  logic [SAMPLE_W-1:0] tap;
  logic [PROD_W-1:0]  tap_x;
  logic [PROD_W-1:0]  coef_x;
  logic [PROD_W-1:0]  prod;

  fir_coef_regfile u_coef (
    .clk   (iClk12M),
    .rst   (iRst),
    .wr    (iCoefWr),
    .allow (state_q == StIdle),
    .addr  (iCoefAddr),
    .wdata (iCoefData),
    .raddr (k_q),
    .rdata (coef_rd),
    .err   (oCoefErr)
  );

  // State register.
  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign last_k = (k_q == CNT_W'(TAPS - 1));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (iEnMac) state_d = StMac;
      StMac:   if (last_k) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Decoded controls.
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    done = 1'b0;
    busy = 1'b1;
    unique case (state_q)
      StIdle: begin
        load = iEnMac;
        busy = 1'b0;
      end
      StMac:   step = 1'b1;
      StDone:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Sign-extend both operands to the product width; the low PROD_W bits are the signed product.
  assign tap    = tap_slice(shadow_q, k_q);
  assign tap_x  = {{COEF_W{tap[SAMPLE_W-1]}}, tap};
  assign coef_x = {{SAMPLE_W{coef_rd[COEF_W-1]}}, coef_rd};
  assign prod   = tap_x * coef_x;

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      shadow_q  <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      mac_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= done;
      overrun_q <= iEnMac & busy;
      if (load) begin
        shadow_q <= iDelay;
        acc_q    <= '0;
        k_q      <= '0;
      end else if (step) begin
        acc_q <= acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        if (!last_k) begin
          k_q <= k_q + 1'b1;
        end
      end
      if (done) begin
        mac_q <= acc_q;
      end
    end
  end

  assign oMac      = mac_q;
  assign oMacValid = valid_q;
  assign oBusy     = busy;
  assign oOverrun  = overrun_q;

endmodule

// File: tb/tb_fir_tap_mac.sv
// Directed self-checking bench for fir_tap_mac: vector table plus overrun/error/reset sequences.
module tb_fir_tap_mac;
  import fir_pkg::*;

  logic        iClk12M = 1'b0;
  logic        iRst;
  logic        iEnMac;
  logic [29:0] iDelay;
  logic        iCoefWr;
  logic [3:0]  iCoefAddr;
  logic [15:0] iCoefData;
  logic [22:0] oMac;
  logic        oMacValid;
  logic        oBusy;
  logic        oOverrun;
  logic        oCoefErr;

  fir_tap_mac dut (
    .iClk12M   (iClk12M),
    .iRst      (iRst),
    .iEnMac    (iEnMac),
    .iDelay    (iDelay),
    .iCoefWr   (iCoefWr),
    .iCoefAddr (iCoefAddr),
    .iCoefData (iCoefData),
    .oMac      (oMac),
    .oMacValid (oMacValid),
    .oBusy     (oBusy),
    .oOverrun  (oOverrun),
    .oCoefErr  (oCoefErr)
  );

  always #5 iClk12M = ~iClk12M;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string        name;
    logic [29:0]  delay;
    logic [159:0] coefs;
    logic [22:0]  exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  task automatic write_coef(input int addr, input logic [15:0] data, input logic exp_err);
    @(posedge iClk12M); #1;
    iCoefWr   = 1'b1;
    iCoefAddr = 4'(addr);
    iCoefData = data;
    @(posedge iClk12M); #1;
    iCoefWr = 1'b0;
    check($sformatf("coef_err_a%0d", addr), 23'(oCoefErr), 23'(exp_err));
  endtask

  task automatic load_coefs(input logic [159:0] c);
    for (int k = 0; k < 10; k++) write_coef(k, c[k*16 +: 16], 1'b0);
  endtask

  // Called at #1 after the edge that sampled iEnMac; returns clocks until oMacValid.
  task automatic wait_valid(output int lat, output int busy);
    lat  = 0;
    busy = 0;
    while (!oMacValid && lat < 40) begin
      if (oBusy) busy++;
      @(posedge iClk12M); #1;
      lat++;
    end
  endtask

  task automatic run_mac(input string name, input logic [22:0] exp);
    int lat, busy;
    @(posedge iClk12M); #1;
    iEnMac = 1'b1;
    @(posedge iClk12M); #1;
    iEnMac = 1'b0;
    wait_valid(lat, busy);
    check({name, "_valid"}, 23'(oMacValid), 23'd1);
    check({name, "_lat"}, 23'(lat), 23'd11);
    check({name, "_busy_cycles"}, 23'(busy), 23'd11);
    check({name, "_busy_at_valid"}, 23'(oBusy), 23'd0);
    check({name, "_value"}, oMac, exp);
    @(posedge iClk12M); #1;
    check({name, "_valid_drop"}, 23'(oMacValid), 23'd0);
    check({name, "_held"}, oMac, exp);
  endtask

  initial begin
    int lat, busy, ov, nv;
    logic [22:0] res;

    iRst = 1'b1; iEnMac = 1'b0; iDelay = '0;
    iCoefWr = 1'b0; iCoefAddr = '0; iCoefData = '0;
    repeat (2) @(posedge iClk12M);
    #1;
    check("rst_mac", oMac, 23'd0);
    check("rst_valid", 23'(oMacValid), 23'd0);
    check("rst_busy", 23'(oBusy), 23'd0);
    check("rst_overrun", 23'(oOverrun), 23'd0);
    check("rst_coef_err", 23'(oCoefErr), 23'd0);
    iRst = 1'b0;

    vecs[0] = '{"ones", {10{3'b001}}, {10{16'h0001}}, 23'd10};
    vecs[1] = '{"impulse5", 30'h1 << 15, 160'h1234 << 80, 23'd4660};
    vecs[2] = '{"impulse0_neg", 30'h1, 160'hFFFF, 23'h7FFFFF};
    vecs[3] = '{"ext_pos_coef", {10{3'b100}}, {10{16'h7FFF}}, -23'sd1310680};
    vecs[4] = '{"ext_neg_coef", {10{3'b100}}, {10{16'h8000}}, 23'd1310720};
    vecs[5] = '{"mixed", {3'b110, 21'b0, 3'b111, 3'b011},
                {16'hFFFB, 112'b0, 16'd200, 16'd100}, 23'd110};

    for (int i = 0; i < 6; i++) begin
      iDelay = vecs[i].delay;
      load_coefs(vecs[i].coefs);
      run_mac(vecs[i].name, vecs[i].exp);
    end

    // Write and start in the same idle clock: MAC must see the new coef3.
    iDelay = {10{3'b001}};
    load_coefs({10{16'h0001}});
    @(posedge iClk12M); #1;
    iEnMac = 1'b1; iCoefWr = 1'b1; iCoefAddr = 4'd3; iCoefData = 16'd5;
    @(posedge iClk12M); #1;
    iEnMac = 1'b0; iCoefWr = 1'b0;
    check("same_clk_err", 23'(oCoefErr), 23'd0);
    wait_valid(lat, busy);
    check("same_clk_lat", 23'(lat), 23'd11);
    check("same_clk_value", oMac, 23'd14);

    // Overrun: second start four clocks into the MAC.
    load_coefs({10{16'h0001}});
    @(posedge iClk12M); #1;
    iEnMac = 1'b1;
    @(posedge iClk12M); #1;
    iEnMac = 1'b0;
    ov = 0; nv = 0; res = '0;
    for (int c = 0; c < 20; c++) begin
      if (oOverrun) ov++;
      if (oMacValid) begin
        nv++;
        res = oMac;
      end
      iEnMac = (c == 4);
      @(posedge iClk12M); #1;
    end
    iEnMac = 1'b0;
    check("overrun_pulses", 23'(ov), 23'd1);
    check("overrun_valid_pulses", 23'(nv), 23'd1);
    check("overrun_value", res, 23'd10);

    // Dropped writes: one while busy, one out of range while idle.
    @(posedge iClk12M); #1;
    iEnMac = 1'b1;
    @(posedge iClk12M); #1;
    iEnMac = 1'b0;
    write_coef(0, 16'h7777, 1'b1);
    wait_valid(lat, busy);
    check("busy_wr_valid", 23'(oMacValid), 23'd1);
    check("busy_wr_value", oMac, 23'd10);
    write_coef(12, 16'h0BAD, 1'b1);
    run_mac("coef_kept", 23'd10);

    // Async reset during the k=6 step, released before the next edge.
    @(posedge iClk12M); #1;
    iEnMac = 1'b1;
    @(posedge iClk12M); #1;
    iEnMac = 1'b0;
    repeat (6) @(posedge iClk12M);
    #1;
    check("mid_busy_before_rst", 23'(oBusy), 23'd1);
    iRst = 1'b1;
    #2;
    check("mid_rst_mac", oMac, 23'd0);
    check("mid_rst_busy", 23'(oBusy), 23'd0);
    check("mid_rst_valid", 23'(oMacValid), 23'd0);
    #2;
    iRst = 1'b0;
    nv = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge iClk12M); #1;
      if (oMacValid) nv++;
    end
    check("mid_rst_no_valid", 23'(nv), 23'd0);
    run_mac("after_rst", 23'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
